matrix_loader: RTL and testbench

//  Producer side of the packed-matrix interface used by the element-wise

---
 rtl/matrix_loader.sv | 197 +++++++++++++++++++
 tb/tb_matrix_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//
// Producer side of the packed-matrix interface feeding the element-wise
// operation units. Matrix elements arrive from the HPS as WORD_W-bit words on
// a valid/ready stream. Each word carries WORD_W/ELEM_W element lanes. The
// words are packed row-major into two operands, first A and then B, for the
// active matrix size. Unused elements are zero-filled. Once both operands are
// complete they are held stable under mat_valid until the consumer
// acknowledges them.
//
// Ports
//   clk          in   1        single clock, rising edge
//   rst          in   1        synchronous, active-high reset
//   start        in   1        begin a new load (honoured only in IDLE)
//   matrix_size  in   2        00=2x2 01=3x3 10=4x4 11=5x5, latched on start
//   in_data      in   WORD_W   element word, lane k = bits [k*ELEM_W +: ELEM_W]
//   in_valid     in   1        in_data is valid
//   in_ready     out  1        loader accepts a word this cycle
//   matrix_A     out  ELEM_W*MAX_ELEM  element i at [i*ELEM_W +: ELEM_W]
//   matrix_B     out  ELEM_W*MAX_ELEM  same layout as matrix_A
//   mat_valid    out  1        A and B complete and stable
//   mat_ack      in   1        consumer has taken A and B
//   busy         out  1        loader is not idle
//   error        out  1        sticky: start seen while not idle
//
// State  | meaning
// IDLE   | waiting for start, operands keep their last values
// LOAD_A | accepting words into operand A
// LOAD_B | accepting words into operand B
// HOLD   | operands complete, mat_valid high until mat_ack
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter int ELEM_W   = 8,
  parameter int MAX_ELEM = 25,
  parameter int WORD_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   matrix_size,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ELEM_W*MAX_ELEM-1:0]   matrix_A,
  output logic [ELEM_W*MAX_ELEM-1:0]   matrix_B,
  output logic                         mat_valid,
  input  logic                         mat_ack,
  output logic                         busy,
  output logic                         error
);

  localparam int LANES     = WORD_W / ELEM_W;
  localparam int MAX_WORDS = (MAX_ELEM + LANES - 1) / LANES;
  // Lane indices of the last word can run past MAX_ELEM-1, so the index
  // width must cover MAX_ELEM+LANES-1.
  localparam int IDX_W     = $clog2(MAX_ELEM + LANES);
  localparam int CNT_W     = $clog2(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state;
  logic [1:0]         size_q;
  logic [CNT_W-1:0]   word_cnt;
  logic [ELEM_W-1:0]  elem_a [MAX_ELEM];
  logic [ELEM_W-1:0]  elem_b [MAX_ELEM];

  logic [IDX_W-1:0]   n_elem;
  logic [CNT_W-1:0]   last_word;
  logic [IDX_W-1:0]   lane_idx [LANES];
  logic               xfer;
  logic               word_done;

  // Element count and index of the final word for the latched size.
  always_comb begin
    n_elem    = IDX_W'(4);
    last_word = CNT_W'(0);
    case (size_q)
      2'b00: begin n_elem = IDX_W'(4);  last_word = CNT_W'(0); end
      2'b01: begin n_elem = IDX_W'(9);  last_word = CNT_W'(2); end
      2'b10: begin n_elem = IDX_W'(16); last_word = CNT_W'(3); end
      2'b11: begin n_elem = IDX_W'(25); last_word = CNT_W'(6); end
      default: begin n_elem = IDX_W'(4); last_word = CNT_W'(0); end
    endcase
  end

  // Destination element index of each lane of the current word.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_idx[k] = IDX_W'(word_cnt) * IDX_W'(LANES) + IDX_W'(k);
    end
  end

  assign xfer      = in_valid && in_ready;
  assign word_done = (word_cnt == last_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      size_q    <= 2'b00;
      word_cnt  <= '0;
      in_ready  <= 1'b0;
      mat_valid <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      for (int i = 0; i < MAX_ELEM; i++) begin
        elem_a[i] <= '0;
        elem_b[i] <= '0;
      end
    end else begin
      // A start outside IDLE never disturbs the load, it only flags it.
      if (start && (state != IDLE)) begin
        error <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            size_q   <= matrix_size;
            word_cnt <= '0;
            error    <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD_A;
            for (int i = 0; i < MAX_ELEM; i++) begin
              elem_a[i] <= '0;
              elem_b[i] <= '0;
            end
          end
        end

        LOAD_A: begin
          if (xfer) begin
            // Lanes beyond the active element count are dropped so the
            // cleared padding stays zero.
            for (int k = 0; k < LANES; k++) begin
              if (lane_idx[k] < n_elem) begin
                elem_a[lane_idx[k]] <= in_data[k*ELEM_W +: ELEM_W];
              end
            end
            if (word_done) begin
              word_cnt <= '0;
              state    <= LOAD_B;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        LOAD_B: begin
          if (xfer) begin
            for (int k = 0; k < LANES; k++) begin
              if (lane_idx[k] < n_elem) begin
                elem_b[lane_idx[k]] <= in_data[k*ELEM_W +: ELEM_W];
              end
            end
            if (word_done) begin
              word_cnt  <= '0;
              in_ready  <= 1'b0;
              mat_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          if (mat_ack) begin
            mat_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          mat_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the element arrays onto the packed operand buses.
  for (genvar g = 0; g < MAX_ELEM; g++) begin : g_pack
    assign matrix_A[g*ELEM_W +: ELEM_W] = elem_a[g];
    assign matrix_B[g*ELEM_W +: ELEM_W] = elem_b[g];
  end

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   matrix_size = 2'b00;
  logic [31:0]  in_data = 32'h0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [199:0] matrix_A;
  logic [199:0] matrix_B;
  logic         mat_valid;
  logic         mat_ack = 1'b0;
  logic         busy;
  logic         error;

  matrix_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_size (matrix_size),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .matrix_A    (matrix_A),
    .matrix_B    (matrix_B),
    .mat_valid   (mat_valid),
    .mat_ack     (mat_ack),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: a load is the list of words accepted since start.
  // Word c < W fills A, word c >= W fills B; element e = 4*word + lane.
  bit          m_active = 1'b0;
  bit          m_err = 1'b0;
  int          m_cnt = 0;
  int          m_n = 4;
  int          m_w = 1;
  logic [7:0]  m_a [25];
  logic [7:0]  m_b [25];

  function automatic logic [199:0] pack(input bit sel_b);
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r[i*8 +: 8] = sel_b ? m_b[i] : m_a[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  always @(posedge clk) begin
    int wi;
    int e;
    if (rst) begin
      m_active = 1'b0;
      m_err    = 1'b0;
      m_cnt    = 0;
      for (int i = 0; i < 25; i++) begin m_a[i] = 8'h0; m_b[i] = 8'h0; end
    end else if (!m_active) begin
      if (start) begin
        m_n = (int'(matrix_size) + 2) * (int'(matrix_size) + 2);
        m_w = (m_n + 3) / 4;
        m_cnt = 0;
        m_err = 1'b0;
        m_active = 1'b1;
        for (int i = 0; i < 25; i++) begin m_a[i] = 8'h0; m_b[i] = 8'h0; end
      end
    end else begin
      if (start) m_err = 1'b1;
      if (m_cnt < 2 * m_w) begin
        if (in_valid) begin
          wi = (m_cnt < m_w) ? m_cnt : m_cnt - m_w;
          for (int k = 0; k < 4; k++) begin
            e = 4 * wi + k;
            if (e < m_n) begin
              if (m_cnt < m_w) m_a[e] = in_data[k*8 +: 8];
              else             m_b[e] = in_data[k*8 +: 8];
            end
          end
          m_cnt++;
        end
      end else if (mat_ack) begin
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  200'(in_ready),  200'(m_active && (m_cnt < 2 * m_w)));
      chk("mat_valid", 200'(mat_valid), 200'(m_active && (m_cnt == 2 * m_w)));
      chk("busy",      200'(busy),      200'(m_active));
      chk("error",     200'(error),     200'(m_err));
      chk("matrix_A",  matrix_A,        pack(1'b0));
      chk("matrix_B",  matrix_B,        pack(1'b1));
    end
  end

  task automatic do_start(input logic [1:0] sz);
    start = 1'b1;
    matrix_size = sz;
    @(negedge clk);
    start = 1'b0;
    matrix_size = 2'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit glitch);
    int tries;
    bit ok;
    tries = 0;
    while (1) begin
      in_valid = 1'b1;
      in_data = w;
      start = glitch;
      ok = in_ready;
      @(negedge clk);
      start = 1'b0;
      if (ok) break;
      tries++;
      if (tries > 50) begin
        fail_timeout("push_word");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [1:0] sz, input int gap_mode, input int glitch_at,
                          input bit force_last, input logic [31:0] last_val);
    int n;
    int w;
    logic [31:0] d;
    n = (int'(sz) + 2) * (int'(sz) + 2);
    w = (n + 3) / 4;
    do_start(sz);
    for (int i = 0; i < 2 * w; i++) begin
      d = $urandom;
      if (force_last && (i == w - 1 || i == 2 * w - 1)) d = last_val;
      if (gap_mode == 1) idle_cycles(1);
      else if (gap_mode == 2) idle_cycles($urandom_range(0, 2));
      push_word(d, i == glitch_at);
    end
  endtask

  task automatic wait_valid();
    int c;
    c = 0;
    while (!mat_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!mat_valid) fail_timeout("wait_mat_valid");
  endtask

  task automatic do_ack(input int delay, input bit with_start);
    wait_valid();
    repeat (delay) @(negedge clk);
    mat_ack = 1'b1;
    start = with_start;
    @(negedge clk);
    mat_ack = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_in_ready",  200'(in_ready),  200'(0));
    chk("reset_mat_valid", 200'(mat_valid), 200'(0));
    chk("reset_busy",      200'(busy),      200'(0));
    chk("reset_matrix_A",  matrix_A,        200'(0));
    rst = 1'b0;
    idle_cycles(2);

    // 1: 2x2, back-to-back words, mat_valid right after the B word edge
    do_start(2'b00);
    push_word(32'h04030201, 1'b0);
    push_word(32'hFCFDFEFF, 1'b0);
    chk("t1_mat_valid", 200'(mat_valid), 200'(1));
    chk("t1_A", matrix_A, 200'h04030201);
    chk("t1_B", matrix_B, 200'hFCFDFEFF);
    do_ack(1, 1'b0);
    chk("t1_mat_valid_after_ack", 200'(mat_valid), 200'(0));
    chk("t1_A_kept", matrix_A, 200'h04030201);

    // 2: 5x5, last word of each matrix only contributes lane 0
    run_load(2'b11, 0, -1, 1'b1, 32'hAABBCC19);
    wait_valid();
    chk("t2_A_elem24", 200'(matrix_A[199:192]), 200'(8'h19));
    chk("t2_B_elem24", 200'(matrix_B[199:192]), 200'(8'h19));
    do_ack(0, 1'b0);

    // 3: 3x3 with in_valid toggling
    run_load(2'b01, 1, -1, 1'b0, 32'h0);
    wait_valid();
    chk("t3_A_upper_zero", 200'(matrix_A[199:72]), 200'(0));
    chk("t3_ready_in_hold", 200'(in_ready), 200'(0));
    do_ack(2, 1'b0);

    // 4: 5x5 followed by 2x2 leaves no residue
    run_load(2'b11, 2, -1, 1'b0, 32'h0);
    do_ack(0, 1'b0);
    run_load(2'b00, 0, -1, 1'b0, 32'h0);
    wait_valid();
    chk("t4_A_upper_zero", 200'(matrix_A[199:32]), 200'(0));
    chk("t4_B_upper_zero", 200'(matrix_B[199:32]), 200'(0));
    do_ack(0, 1'b0);

    // 5: start during LOAD_A and in HOLD flags error, load unaffected
    run_load(2'b10, 0, 1, 1'b0, 32'h0);
    wait_valid();
    chk("t5_error_load", 200'(error), 200'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_valid_kept", 200'(mat_valid), 200'(1));
    do_ack(0, 1'b1);
    chk("t5_error_sticky", 200'(error), 200'(1));
    do_start(2'b00);
    chk("t5_error_cleared", 200'(error), 200'(0));
    push_word($urandom, 1'b0);
    push_word($urandom, 1'b0);
    do_ack(0, 1'b0);

    // 6: reset in the middle of a 4x4 load
    do_start(2'b10);
    for (int i = 0; i < 6; i++) push_word($urandom, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy",      200'(busy),      200'(0));
    chk("t6_in_ready",  200'(in_ready),  200'(0));
    chk("t6_mat_valid", 200'(mat_valid), 200'(0));
    chk("t6_A_zero",    matrix_A,        200'(0));
    chk("t6_B_zero",    matrix_B,        200'(0));
    run_load(2'b10, 2, -1, 1'b0, 32'h0);
    do_ack(1, 1'b0);

    // random loads, stray acks while idle
    for (int r = 0; r < 12; r++) begin
      mat_ack = $urandom_range(0, 1);
      idle_cycles($urandom_range(0, 3));
      mat_ack = 1'b0;
      run_load(2'($urandom_range(0, 3)), 2, -1, 1'b0, 32'h0);
      do_ack($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
